// File: rtl/jmp_ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jmp_ras_ctrl
// Purpose  : Jump-control decoder with return-address-stack (RAS) prediction.
//            Decodes JR / JALR / JAL into the register-jump mux select and the
//            R7 link write enable. JAL/JALR push their return address onto a
//            circular RAS; JR pops it and checks the prediction against the
//            resolved register target. A mispredict starts a fixed-length
//            flush of the fetch/decode pipeline registers.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            valid, stall    - decode handshake (accepted: valid & ~stall & ~flush)
//            opcode          - decode opcode
//            pc_plus2        - return address of the current instruction
//            rs_data         - resolved register jump target
//            jr_en, reg_7_en - combinational decode outputs
//            pred_valid/addr - RAS non-empty flag and top-of-stack entry
//            flush           - registered mispredict flush
//            ras_count       - RAS occupancy
//            ovf/unf_sticky  - overflow / underflow history flags
//            hit/miss_cnt    - saturating prediction statistics
// Revision : 1.0 - initial release
// ============================================================================
module jmp_ras_ctrl #(
    parameter int               DATA_W    = 16,
    parameter int               DEPTH     = 8,
    parameter int               OPC_W     = 5,
    parameter logic [OPC_W-1:0] OPC_JR    = 5'b00101,
    parameter logic [OPC_W-1:0] OPC_JALR  = 5'b00111,
    parameter logic [OPC_W-1:0] OPC_JAL   = 5'b00110,
    parameter int               FLUSH_CYC = 2,
    parameter int               CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid,
    input  logic                      stall,
    input  logic [OPC_W-1:0]          opcode,
    input  logic [DATA_W-1:0]         pc_plus2,
    input  logic [DATA_W-1:0]         rs_data,
    output logic                      jr_en,
    output logic                      reg_7_en,
    output logic                      pred_valid,
    output logic [DATA_W-1:0]         pred_addr,
    output logic                      flush,
    output logic [$clog2(DEPTH):0]    ras_count,
    output logic                      ovf_sticky,
    output logic                      unf_sticky,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    // Flush countdown wide enough to hold FLUSH_CYC-1 for any FLUSH_CYC >= 1.
    localparam int FC_W  = $clog2(FLUSH_CYC) + 1;

    localparam logic [PTR_W:0]   C_FULL_CNT   = (PTR_W + 1)'(DEPTH);
    localparam logic [FC_W-1:0]  C_FLUSH_LOAD = FC_W'(FLUSH_CYC - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ent_q [DEPTH];
    logic [DATA_W-1:0] ent_d [DEPTH];
    logic [PTR_W-1:0]  tos_q,      tos_d;
    logic [PTR_W:0]    count_q,    count_d;
    state_t            state_q,    state_d;
    logic [FC_W-1:0]   fcnt_q,     fcnt_d;
    logic              flush_q,    flush_d;
    logic              ovf_q,      ovf_d;
    logic              unf_q,      unf_d;
    logic [CNT_W-1:0]  hit_q,      hit_d;
    logic [CNT_W-1:0]  miss_q,     miss_d;

    // ------------------------------------------------------------------
    // Decode (opcode only, independent of valid)
    // ------------------------------------------------------------------
    logic op_jr;
    logic op_jalr;
    logic op_jal;

    assign op_jr    = (opcode == OPC_JR);
    assign op_jalr  = (opcode == OPC_JALR);
    assign op_jal   = (opcode == OPC_JAL);
    assign jr_en    = op_jr | op_jalr;
    assign reg_7_en = op_jal | op_jalr;

    // ------------------------------------------------------------------
    // Prediction
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] top_idx;
    logic             acc;
    logic             do_push;
    logic             do_pop;
    logic             pred_hit;
    logic             pred_miss;

    // tos points at the next free slot; the top entry sits one below (mod DEPTH).
    assign top_idx    = tos_q - PTR_W'(1);
    assign pred_valid = (count_q != '0);
    assign pred_addr  = ent_q[top_idx];

    assign acc       = valid & ~stall & ~flush_q;
    assign do_push   = acc & (op_jal | op_jalr);
    assign do_pop    = acc & op_jr;
    assign pred_hit  = do_pop & pred_valid & (rs_data == pred_addr);
    assign pred_miss = do_pop & ~pred_hit;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ent_d   = ent_q;
        tos_d   = tos_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        hit_d   = hit_q;
        miss_d  = miss_q;

        if (do_push) begin
            ent_d[tos_q] = pc_plus2;
            tos_d        = tos_q + PTR_W'(1);
            // When full the write lands on the oldest entry; occupancy holds.
            if (count_q == C_FULL_CNT) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + (PTR_W + 1)'(1);
            end
        end

        if (do_pop) begin
            if (pred_valid) begin
                // Popped on both hit and miss: the return is consumed either way.
                tos_d   = top_idx;
                count_d = count_q - (PTR_W + 1)'(1);
            end else begin
                unf_d = 1'b1;
            end
        end

        if (pred_hit && (hit_q != '1)) begin
            hit_d = hit_q + CNT_W'(1);
        end
        if (pred_miss && (miss_q != '1)) begin
            miss_d = miss_q + CNT_W'(1);
        end
    end

    // Flush sequencer; the countdown runs regardless of stall.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pred_miss) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = C_FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = '0;
            end
        endcase
        // Registered copy of the next state so flush rises the cycle after the miss.
        flush_d = (state_d == ST_FLUSH);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            tos_q   <= '0;
            count_q <= '0;
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
            flush_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            tos_q   <= tos_d;
            count_q <= count_d;
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            flush_q <= flush_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign flush      = flush_q;
    assign ras_count  = count_q;
    assign ovf_sticky = ovf_q;
    assign unf_sticky = unf_q;
    assign hit_cnt    = hit_q;
    assign miss_cnt   = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_jmp_ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jmp_ras_ctrl
// Purpose  : Directed self-checking bench for jmp_ras_ctrl with hand-computed
//            expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jmp_ras_ctrl;

    localparam logic [4:0] C_JR   = 5'b00101;
    localparam logic [4:0] C_JALR = 5'b00111;
    localparam logic [4:0] C_JAL  = 5'b00110;
    localparam logic [4:0] C_NOP  = 5'b00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        stall = 1'b0;
    logic [4:0]  opcode = 5'b0;
    logic [15:0] pc_plus2 = 16'h0;
    logic [15:0] rs_data = 16'h0;
    logic        jr_en;
    logic        reg_7_en;
    logic        pred_valid;
    logic [15:0] pred_addr;
    logic        flush;
    logic [3:0]  ras_count;
    logic        ovf_sticky;
    logic        unf_sticky;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    jmp_ras_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .stall      (stall),
        .opcode     (opcode),
        .pc_plus2   (pc_plus2),
        .rs_data    (rs_data),
        .jr_en      (jr_en),
        .reg_7_en   (reg_7_en),
        .pred_valid (pred_valid),
        .pred_addr  (pred_addr),
        .flush      (flush),
        .ras_count  (ras_count),
        .ovf_sticky (ovf_sticky),
        .unf_sticky (unf_sticky),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for one clock edge; returns 1 ns after the edge
    // with the bus idle again.
    task automatic step(input logic v, input logic s, input logic [4:0] op,
                        input logic [15:0] pc, input logic [15:0] rs);
        valid    = v;
        stall    = s;
        opcode   = op;
        pc_plus2 = pc;
        rs_data  = rs;
        @(posedge clk);
        #1;
        valid  = 1'b0;
        stall  = 1'b0;
        opcode = C_NOP;
    endtask

    initial begin
        // ---------------- reset ----------------
        #12;
        chk("rst_count", ras_count, 0);
        chk("rst_pvalid", pred_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_hit", hit_cnt, 0);
        chk("rst_miss", miss_cnt, 0);
        chk("rst_ovf", ovf_sticky, 0);
        chk("rst_unf", unf_sticky, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- single JAL ----------------
        opcode = C_JAL;
        #1;
        chk("jal_reg7", reg_7_en, 1);
        chk("jal_jren", jr_en, 0);
        step(1, 0, C_JAL, 16'h0010, 16'h0);
        chk("jal_count", ras_count, 1);
        chk("jal_pvalid", pred_valid, 1);
        chk("jal_paddr", pred_addr, 16'h0010);

        // ---------------- push 0x20, two hits ----------------
        step(1, 0, C_JAL, 16'h0020, 16'h0);
        chk("push2_count", ras_count, 2);
        chk("push2_paddr", pred_addr, 16'h0020);
        step(1, 0, C_JR, 16'h0, 16'h0020);
        chk("hit1_flush", flush, 0);
        chk("hit1_paddr", pred_addr, 16'h0010);
        step(1, 0, C_JR, 16'h0, 16'h0010);
        chk("hit2_flush", flush, 0);
        chk("hit2_cnt", hit_cnt, 2);
        chk("hit2_count", ras_count, 0);
        chk("hit2_pvalid", pred_valid, 0);
        chk("hit2_miss", miss_cnt, 0);

        // ---------------- mispredict and flush ----------------
        step(1, 0, C_JAL, 16'h0010, 16'h0);
        step(1, 0, C_JR, 16'h0, 16'h0044);
        chk("mis_flush1", flush, 1);
        chk("mis_cnt", miss_cnt, 1);
        chk("mis_count", ras_count, 0);
        step(1, 0, C_JAL, 16'h0099, 16'h0);
        chk("mis_flush2", flush, 1);
        chk("mis_ign1", ras_count, 0);
        step(1, 0, C_JAL, 16'h0099, 16'h0);
        chk("mis_flush3", flush, 0);
        chk("mis_ign2", ras_count, 0);
        step(0, 0, C_NOP, 16'h0, 16'h0);
        chk("mis_flush4", flush, 0);
        chk("mis_hitkeep", hit_cnt, 2);

        // ---------------- overflow: 9 pushes, 8 hits ----------------
        for (int i = 1; i <= 9; i++) begin
            step(1, 0, C_JAL, 16'(2 * i), 16'h0);
        end
        chk("ovf_count", ras_count, 8);
        chk("ovf_sticky", ovf_sticky, 1);
        chk("ovf_paddr", pred_addr, 16'h0012);
        for (int i = 9; i >= 2; i--) begin
            chk("ovf_pop_addr", pred_addr, 32'(2 * i));
            step(1, 0, C_JR, 16'h0, 16'(2 * i));
            chk("ovf_pop_flush", flush, 0);
        end
        chk("ovf_hits", hit_cnt, 10);
        chk("ovf_empty", ras_count, 0);
        chk("ovf_pvalid", pred_valid, 0);
        chk("ovf_miss", miss_cnt, 1);

        // ---------------- underflow ----------------
        chk("unf_pre", unf_sticky, 0);
        step(1, 0, C_JR, 16'h0, 16'h0000);
        chk("unf_sticky", unf_sticky, 1);
        chk("unf_miss", miss_cnt, 2);
        chk("unf_flush", flush, 1);
        chk("unf_count", ras_count, 0);
        step(0, 0, C_NOP, 16'h0, 16'h0);
        step(0, 0, C_NOP, 16'h0, 16'h0);
        chk("unf_flush_end", flush, 0);
        step(1, 1, C_JR, 16'h0, 16'h0);
        chk("stall_miss", miss_cnt, 2);
        chk("stall_flush", flush, 0);
        step(0, 0, C_JR, 16'h0, 16'h0);
        chk("nval_miss", miss_cnt, 2);
        chk("nval_flush", flush, 0);
        opcode = C_JALR;
        #1;
        chk("jalr_jren", jr_en, 1);
        chk("jalr_reg7", reg_7_en, 1);
        opcode = C_JR;
        #1;
        chk("jr_jren", jr_en, 1);
        chk("jr_reg7", reg_7_en, 0);
        opcode = C_NOP;
        #1;
        chk("nop_jren", jr_en, 0);
        chk("nop_reg7", reg_7_en, 0);
        @(posedge clk);
        #1;

        // ---------------- JALR push, then async reset mid-flush ----------------
        step(1, 0, C_JALR, 16'h0100, 16'h0);
        step(1, 0, C_JAL, 16'h0200, 16'h0);
        step(1, 0, C_JAL, 16'h0300, 16'h0);
        step(1, 0, C_JALR, 16'h0400, 16'h0);
        chk("pre_count", ras_count, 4);
        step(1, 0, C_JR, 16'h0, 16'h0555);
        chk("pre_flush", flush, 1);
        chk("pre_count3", ras_count, 3);
        chk("pre_paddr", pred_addr, 16'h0300);
        chk("pre_miss", miss_cnt, 3);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_flush", flush, 0);
        chk("arst_count", ras_count, 0);
        chk("arst_hit", hit_cnt, 0);
        chk("arst_miss", miss_cnt, 0);
        chk("arst_ovf", ovf_sticky, 0);
        chk("arst_unf", unf_sticky, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, C_NOP, 16'h0, 16'h0);
        chk("post_flush", flush, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
